mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM (registered read data) between a CPU port and
//   a debug/dump port. The CPU wins by default. After MAX_WAIT consecutive
//   denied debug cycles the debug port is forced a grant. A registered
//   read-owner tag routes the returning read data to the port that issued the
//   read in the previous cycle.
//
// Ports
//   clock                 system clock, all state on rising edge
//   reset                 synchronous, active-low reset
//   cpu_req/we/addr/wdata CPU request side
//   cpu_gnt               CPU access granted this cycle
//   cpu_rvalid/rdata      CPU read return (rdata holds when rvalid=0)
//   dbg_req/we/addr/wdata debug request side
//   dbg_gnt               debug access granted this cycle
//   dbg_rvalid/rdata      debug read return (rdata holds when rvalid=0)
//   mem_we/addr/din       RAM command, driven from the granted port
//   mem_dout              RAM read data, valid one cycle after the address
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned WCNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_t;

  owner_t            owner_q, owner_d;
  logic [WCNT_W-1:0] wcnt, wcnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              force_dbg;

  // Arbitration; everything is gated by reset so nothing reaches the RAM
  // while reset is low.
  always_comb begin
    force_dbg = reset && dbg_req && (wcnt == WCNT_MAX);
    cpu_gnt   = reset && cpu_req && !force_dbg;
    dbg_gnt   = reset && dbg_req && (force_dbg || !cpu_req);
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_din  = dbg_wdata;
    end
  end

  // Next-state for the wait counter and the read-owner tag.
  always_comb begin
    wcnt_d  = '0;
    owner_d = OWN_NONE;
    if (reset) begin
      if (dbg_req && !dbg_gnt)
        wcnt_d = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;
      if (cpu_gnt && !cpu_we)
        owner_d = OWN_CPU;
      else if (dbg_gnt && !dbg_we)
        owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wcnt    <= '0;
      owner_q <= OWN_NONE;
    end else begin
      wcnt    <= wcnt_d;
      owner_q <= owner_d;
    end
  end

  // Read return: rvalid comes straight from the tag (gated by reset so a
  // read issued just before reset never reports), and the rdata holding
  // registers capture mem_dout only on the owning port's rvalid cycle.
  always_comb begin
    cpu_rvalid = reset && (owner_q == OWN_CPU);
    dbg_rvalid = reset && (owner_q == OWN_DBG);
    cpu_rdata  = '0;
    dbg_rdata  = '0;
    if (reset) begin
      cpu_rdata = cpu_rvalid ? mem_dout : cpu_rdata_q;
      dbg_rdata = dbg_rvalid ? mem_dout : dbg_rdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_dout;
      if (dbg_rvalid) dbg_rdata_q <= mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  // RAM environment: synchronous write, registered read.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 16'h1234;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h56; dbg_wdata = 16'h4321;
    tick(); tick(); #2;
    compared++; if (cpu_gnt !== 1'b0) begin mismatched++; $display("FAIL rst_cpu_gnt got %b want 0", cpu_gnt); end
    compared++; if (dbg_gnt !== 1'b0) begin mismatched++; $display("FAIL rst_dbg_gnt got %b want 0", dbg_gnt); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    compared++; if (mem_addr !== 8'h00) begin mismatched++; $display("FAIL rst_mem_addr got %h want 00", mem_addr); end
    compared++; if (mem_din !== 16'h0000) begin mismatched++; $display("FAIL rst_mem_din got %h want 0000", mem_din); end
    compared++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin mismatched++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, dbg_rvalid}); end
    compared++; if ({cpu_rdata, dbg_rdata} !== 32'h0) begin mismatched++; $display("FAIL rst_rdata got %h want 0", {cpu_rdata, dbg_rdata}); end
    compared++; if (dut.wcnt !== 3'd0) begin mismatched++; $display("FAIL rst_wcnt got %0d want 0", dut.wcnt); end
    idle(); reset = 1;
    tick(); #2;
    compared++; if (ram[8'h55] !== 16'h7777) begin mismatched++; $display("FAIL rst_no_write got %h want 7777", ram[8'h55]); end
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12; #2;
    compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL rd_cpu_gnt got %b want 1", cpu_gnt); end
    compared++; if (mem_addr !== 8'h12) begin mismatched++; $display("FAIL rd_mem_addr got %h want 12", mem_addr); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rd_mem_we got %b want 0", mem_we); end
    tick(); idle(); #2;
    compared++; if (cpu_rvalid !== 1'b1) begin mismatched++; $display("FAIL rd_cpu_rvalid got %b want 1", cpu_rvalid); end
    compared++; if (cpu_rdata !== 16'hBEEF) begin mismatched++; $display("FAIL rd_cpu_rdata got %h want BEEF", cpu_rdata); end
    compared++; if (dbg_rvalid !== 1'b0) begin mismatched++; $display("FAIL rd_dbg_rvalid got %b want 0", dbg_rvalid); end
    tick(); #2;
    compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("FAIL rd_pulse got %b want 0", cpu_rvalid); end
    compared++; if (cpu_rdata !== 16'hBEEF) begin mismatched++; $display("FAIL rd_hold got %h want BEEF", cpu_rdata); end
    tick();
  endtask

  task automatic test_alternating();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01; #2;
    compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL alt_cpu_gnt got %b want 1", cpu_gnt); end
    tick(); idle(); dbg_req = 1; dbg_addr = 8'h02; #2;
    compared++; if (dbg_gnt !== 1'b1) begin mismatched++; $display("FAIL alt_dbg_gnt got %b want 1", dbg_gnt); end
    compared++; if ({cpu_rvalid, dbg_rvalid} !== 2'b10) begin mismatched++; $display("FAIL alt_rv1 got %b want 10", {cpu_rvalid, dbg_rvalid}); end
    compared++; if (cpu_rdata !== 16'h1111) begin mismatched++; $display("FAIL alt_cpu_rdata got %h want 1111", cpu_rdata); end
    tick(); idle(); #2;
    compared++; if ({cpu_rvalid, dbg_rvalid} !== 2'b01) begin mismatched++; $display("FAIL alt_rv2 got %b want 01", {cpu_rvalid, dbg_rvalid}); end
    compared++; if (dbg_rdata !== 16'h2222) begin mismatched++; $display("FAIL alt_dbg_rdata got %h want 2222", dbg_rdata); end
    compared++; if (cpu_rdata !== 16'h1111) begin mismatched++; $display("FAIL alt_cpu_hold got %h want 1111", cpu_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_w;
    cpu_req = 1; cpu_addr = 8'h01; dbg_req = 1; dbg_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #2;
      exp_w = 3'(i);
      compared++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin mismatched++; $display("FAIL stv_gnt c%0d got %b want 10", i, {cpu_gnt, dbg_gnt}); end
      compared++; if (dut.wcnt !== exp_w) begin mismatched++; $display("FAIL stv_wcnt c%0d got %0d want %0d", i, dut.wcnt, exp_w); end
      tick();
    end
    #2;
    compared++; if ({cpu_gnt, dbg_gnt} !== 2'b01) begin mismatched++; $display("FAIL stv_force got %b want 01", {cpu_gnt, dbg_gnt}); end
    compared++; if (mem_addr !== 8'h02) begin mismatched++; $display("FAIL stv_mem_addr got %h want 02", mem_addr); end
    compared++; if (cpu_rdata !== 16'h1111 || cpu_rvalid !== 1'b1) begin mismatched++; $display("FAIL stv_cpu_ret got %b/%h want 1/1111", cpu_rvalid, cpu_rdata); end
    tick(); #2;
    compared++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin mismatched++; $display("FAIL stv_resume got %b want 10", {cpu_gnt, dbg_gnt}); end
    compared++; if (dut.wcnt !== 3'd0) begin mismatched++; $display("FAIL stv_wcnt_clr got %0d want 0", dut.wcnt); end
    compared++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h2222) begin mismatched++; $display("FAIL stv_dbg_ret got %b/%h want 1/2222", dbg_rvalid, dbg_rdata); end
    tick(); idle(); tick(); tick();
  endtask

  task automatic test_dbg_write();
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 16'hA5A5; #2;
    compared++; if ({cpu_gnt, dbg_gnt} !== 2'b01) begin mismatched++; $display("FAIL wr_gnt got %b want 01", {cpu_gnt, dbg_gnt}); end
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
    compared++; if (mem_addr !== 8'h40) begin mismatched++; $display("FAIL wr_mem_addr got %h want 40", mem_addr); end
    compared++; if (mem_din !== 16'hA5A5) begin mismatched++; $display("FAIL wr_mem_din got %h want A5A5", mem_din); end
    tick(); idle(); #2;
    compared++; if (dbg_rvalid !== 1'b0) begin mismatched++; $display("FAIL wr_no_rvalid got %b want 0", dbg_rvalid); end
    tick();
    cpu_req = 1; cpu_addr = 8'h40;
    tick(); idle(); #2;
    compared++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hA5A5) begin mismatched++; $display("FAIL wr_readback got %b/%h want 1/A5A5", cpu_rvalid, cpu_rdata); end
    tick();
  endtask

  task automatic test_cancel();
    cpu_req = 1; cpu_addr = 8'h03;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h60; dbg_wdata = 16'hDEAD; #2;
    compared++; if (dbg_gnt !== 1'b0) begin mismatched++; $display("FAIL cx_gnt0 got %b want 0", dbg_gnt); end
    tick(); #2;
    compared++; if (dbg_gnt !== 1'b0 || dut.wcnt !== 3'd1) begin mismatched++; $display("FAIL cx_c1 got gnt=%b wcnt=%0d want 0/1", dbg_gnt, dut.wcnt); end
    tick(); dbg_req = 0; #2;
    compared++; if (dbg_gnt !== 1'b0 || dut.wcnt !== 3'd2) begin mismatched++; $display("FAIL cx_c2 got gnt=%b wcnt=%0d want 0/2", dbg_gnt, dut.wcnt); end
    tick(); #2;
    compared++; if (dut.wcnt !== 3'd0) begin mismatched++; $display("FAIL cx_wcnt got %0d want 0", dut.wcnt); end
    compared++; if (dbg_rvalid !== 1'b0) begin mismatched++; $display("FAIL cx_rvalid got %b want 0", dbg_rvalid); end
    idle(); tick(); #2;
    compared++; if (ram[8'h60] !== 16'h0BAD) begin mismatched++; $display("FAIL cx_no_write got %h want 0BAD", ram[8'h60]); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12; #2;
    compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL rmr_gnt got %b want 1", cpu_gnt); end
    tick();
    reset = 0; cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 16'h1234; #2;
    compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("FAIL rmr_rvalid got %b want 0", cpu_rvalid); end
    compared++; if (cpu_gnt !== 1'b0 || mem_we !== 1'b0) begin mismatched++; $display("FAIL rmr_gnt_off got %b/%b want 0/0", cpu_gnt, mem_we); end
    compared++; if (cpu_rdata !== 16'h0000 || mem_addr !== 8'h00) begin mismatched++; $display("FAIL rmr_outs got %h/%h want 0000/00", cpu_rdata, mem_addr); end
    tick(); idle(); reset = 1; #2;
    compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("FAIL rmr_post_rvalid got %b want 0", cpu_rvalid); end
    compared++; if (dut.wcnt !== 3'd0) begin mismatched++; $display("FAIL rmr_wcnt got %0d want 0", dut.wcnt); end
    compared++; if (ram[8'h55] !== 16'h7777) begin mismatched++; $display("FAIL rmr_no_write got %h want 7777", ram[8'h55]); end
    tick();
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
    ram[8'h01] = 16'h1111;
    ram[8'h02] = 16'h2222;
    ram[8'h12] = 16'hBEEF;
    ram[8'h55] = 16'h7777;
    ram[8'h60] = 16'h0BAD;
    reset = 0;
    idle();
    tick();
    test_reset();
    test_cpu_read();
    test_alternating();
    test_starvation();
    test_dbg_write();
    test_cancel();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
